mmio_timer_led: RTL and testbench

Memory-mapped I/O responder for the 6502 core. It answers CPU bus cycles in a small address window alongside `cpumemory`, on the same `mw`/address/data interface. It holds the LED output register and an 8-bit down-counting interval timer with prescaler, expiry flag and interrupt request. The top-level read mux selects its `data_out` whenever `sel` is high.

---
 rtl/mmio_timer_led.sv | 135 +++++++++++++
 tb/tb_mmio_timer_led.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_led.sv
// Bus-mapped LED register plus an 8-bit down-counting interval timer with prescaler,
// expiry flag and interrupt request. One-cycle registered read path, like cpumemory.
module mmio_timer_led #(
  parameter logic [15:0] BASE_ADDR = 16'hFF00,
  parameter logic [7:0]  LED_RESET = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mw_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_in_i,
  output logic [7:0]  data_out_o,
  output logic        sel_o,
  output logic [7:0]  led_o,
  output logic        irq_o
);

  localparam logic [2:0] OffLed      = 3'd0;
  localparam logic [2:0] OffCtrl     = 3'd1;
  localparam logic [2:0] OffReload   = 3'd2;
  localparam logic [2:0] OffCount    = 3'd3;
  localparam logic [2:0] OffPrescale = 3'd4;

  logic [7:0] led_q, led_d;
  logic       enable_q, enable_d;
  logic       autoreload_q, autoreload_d;
  logic       irqen_q, irqen_d;
  logic       expired_q, expired_d;
  logic [7:0] reload_q, reload_d;
  logic [7:0] count_q, count_d;
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] psc_q, psc_d;
  logic [7:0] data_out_q, data_out_d;
  logic       sel_q, sel_d;

  logic       hit, wr;
  logic [2:0] off;
  logic       wr_led, wr_ctrl, wr_reload, wr_prescale;
  logic       tick, expire;
  logic [7:0] rdata;

  always_comb begin
    hit         = (addr_i[15:3] == BASE_ADDR[15:3]);
    wr          = hit & mw_i;
    off         = addr_i[2:0];
    wr_led      = wr && (off == OffLed);
    wr_ctrl     = wr && (off == OffCtrl);
    wr_reload   = wr && (off == OffReload);
    wr_prescale = wr && (off == OffPrescale);
    tick        = enable_q && (psc_q == prescale_q);
    // A RELOAD write on a tick edge reloads the counter and suppresses expiry.
    expire      = tick && (count_q == 8'h00) && !wr_reload;
  end

  always_comb begin
    led_d        = wr_led      ? data_in_i : led_q;
    reload_d     = wr_reload   ? data_in_i : reload_q;
    prescale_d   = wr_prescale ? data_in_i : prescale_q;
    autoreload_d = autoreload_q;
    irqen_d      = irqen_q;

    psc_d = psc_q;
    if (enable_q) psc_d = tick ? 8'h00 : psc_q + 8'd1;
    if (wr_reload) psc_d = 8'h00;

    count_d = count_q;
    if (tick) begin
      if (count_q != 8'h00)  count_d = count_q - 8'd1;
      else if (autoreload_q) count_d = reload_q;
    end
    if (wr_reload) count_d = data_in_i;

    // Software writes to CTRL take priority over the one-shot auto-disable.
    enable_d = enable_q;
    if (expire && !autoreload_q) enable_d = 1'b0;
    if (wr_ctrl) begin
      enable_d     = data_in_i[0];
      autoreload_d = data_in_i[1];
      irqen_d      = data_in_i[2];
    end

    // Clear first so that a simultaneous expiry wins.
    expired_d = expired_q;
    if (wr_ctrl && data_in_i[7]) expired_d = 1'b0;
    if (expire) expired_d = 1'b1;
  end

  always_comb begin
    rdata = 8'h00;
    case (off)
      OffLed:      rdata = led_q;
      OffCtrl:     rdata = {expired_q, 4'b0000, irqen_q, autoreload_q, enable_q};
      OffReload:   rdata = reload_q;
      OffCount:    rdata = count_q;
      OffPrescale: rdata = prescale_q;
      default:     rdata = 8'h00;
    endcase
    data_out_d = hit ? rdata : data_out_q;
    sel_d      = hit;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      led_q        <= LED_RESET;
      enable_q     <= 1'b0;
      autoreload_q <= 1'b0;
      irqen_q      <= 1'b0;
      expired_q    <= 1'b0;
      reload_q     <= 8'h00;
      count_q      <= 8'h00;
      prescale_q   <= 8'h00;
      psc_q        <= 8'h00;
      data_out_q   <= 8'h00;
      sel_q        <= 1'b0;
    end else begin
      led_q        <= led_d;
      enable_q     <= enable_d;
      autoreload_q <= autoreload_d;
      irqen_q      <= irqen_d;
      expired_q    <= expired_d;
      reload_q     <= reload_d;
      count_q      <= count_d;
      prescale_q   <= prescale_d;
      psc_q        <= psc_d;
      data_out_q   <= data_out_d;
      sel_q        <= sel_d;
    end
  end

  assign data_out_o = data_out_q;
  assign sel_o      = sel_q;
  assign led_o      = led_q;
  assign irq_o      = expired_q & irqen_q;

endmodule

// File: tb/tb_mmio_timer_led.sv
// Scoreboard bench for mmio_timer_led: bus cycles queue their expected sel/data_out,
// a negedge monitor pops and compares one cycle later.
module tb_mmio_timer_led;

  logic        clk = 1'b0;
  logic        reset;
  logic        mw;
  logic [15:0] addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        sel;
  logic [7:0]  led;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         due;
    logic       sel;
    logic [7:0] data;
    string      name;
  } exp_t;

  exp_t sb[$];

  mmio_timer_led #(
    .BASE_ADDR(16'hFF00),
    .LED_RESET(8'h00)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .mw_i      (mw),
    .addr_i    (addr),
    .data_in_i (din),
    .data_out_o(dout),
    .sel_o     (sel),
    .led_o     (led),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: the response to a bus cycle captured at edge k is visible after edge k.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (sel !== e.sel || (e.sel && dout !== e.data)) begin
        errors++;
        $display("FAIL %s: got sel=%b data=%h expected sel=%b data=%h",
                 e.name, sel, dout, e.sel, e.data);
      end
    end
  end

  task automatic bus(input logic w, input logic [15:0] a, input logic [7:0] d,
                     input logic es, input logic [7:0] ed, input string nm);
    exp_t e;
    mw   = w;
    addr = a;
    din  = d;
    e.due  = cyc + 1;
    e.sel  = es;
    e.data = ed;
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    mw   = 1'b0;
    addr = 16'h0000;
    din  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [7:0] auto_seq[6];
  int n;

  initial begin
    auto_seq = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h04};
    reset = 1'b1;
    mw    = 1'b0;
    addr  = 16'h0000;
    din   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_led", led, 8'h00);
    check("rst_sel", {7'b0, sel}, 8'h00);
    check("rst_dout", dout, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 8; i++) bus(1'b0, 16'hFF00 + 16'(i), 8'h00, 1'b1, 8'h00, "rd_reset");

    // LED write and window decode.
    bus(1'b1, 16'hFF00, 8'hA5, 1'b1, 8'h00, "wr_led");
    check("led_after_wr", led, 8'hA5);
    bus(1'b0, 16'hFF00, 8'h00, 1'b1, 8'hA5, "rd_led");
    bus(1'b1, 16'hFF08, 8'h5A, 1'b0, 8'h00, "wr_miss");
    check("led_after_miss", led, 8'hA5);

    // One-shot: (2+1)*(3+1) = 12 clocks to expiry.
    bus(1'b1, 16'hFF04, 8'h03, 1'b1, 8'h00, "wr_presc");
    bus(1'b1, 16'hFF02, 8'h02, 1'b1, 8'h00, "wr_reload");
    bus(1'b1, 16'hFF01, 8'h05, 1'b1, 8'h00, "wr_ctrl_os");
    n = 0;
    while (irq !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("oneshot_latency", 8'(n), 8'd12);
    check("oneshot_irq", {7'b0, irq}, 8'h01);
    bus(1'b0, 16'hFF01, 8'h00, 1'b1, 8'h84, "rd_ctrl_os");
    bus(1'b0, 16'hFF03, 8'h00, 1'b1, 8'h00, "rd_count_os");

    // Autoreload with PRESCALE=0: expiry every 5 cycles.
    bus(1'b1, 16'hFF01, 8'h80, 1'b1, 8'h84, "wr_ctrl_clr");
    check("irq_after_clr", {7'b0, irq}, 8'h00);
    bus(1'b1, 16'hFF04, 8'h00, 1'b1, 8'h03, "wr_presc0");
    bus(1'b1, 16'hFF02, 8'h04, 1'b1, 8'h02, "wr_reload4");
    bus(1'b1, 16'hFF01, 8'h03, 1'b1, 8'h00, "wr_ctrl_ar");
    for (int i = 0; i < 6; i++) bus(1'b0, 16'hFF03, 8'h00, 1'b1, auto_seq[i], "rd_count_ar");
    bus(1'b1, 16'hFF01, 8'h83, 1'b1, 8'h83, "wr_clr_quiet");
    bus(1'b0, 16'hFF01, 8'h00, 1'b1, 8'h03, "rd_ctrl_cleared");
    idle(1);
    bus(1'b1, 16'hFF01, 8'h83, 1'b1, 8'h03, "wr_clr_on_expiry");
    bus(1'b0, 16'hFF01, 8'h00, 1'b1, 8'h83, "rd_ctrl_setwins");

    // RELOAD write on a tick edge wins over the decrement.
    bus(1'b1, 16'hFF02, 8'h09, 1'b1, 8'h04, "wr_reload_tick");
    bus(1'b0, 16'hFF03, 8'h00, 1'b1, 8'h09, "rd_count_coll");
    bus(1'b0, 16'hFF03, 8'h00, 1'b1, 8'h08, "rd_count_8");
    bus(1'b0, 16'hFF03, 8'h00, 1'b1, 8'h07, "rd_count_7");
    bus(1'b0, 16'hFF03, 8'h00, 1'b1, 8'h06, "rd_count_6");

    // Reset with COUNT=5 while enabled; timer must stay stopped.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_rst_sel", {7'b0, sel}, 8'h00);
    check("mid_rst_dout", dout, 8'h00);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_irq", {7'b0, irq}, 8'h00);
    idle(5);
    for (int i = 0; i < 8; i++) bus(1'b0, 16'hFF00 + 16'(i), 8'h00, 1'b1, 8'h00, "rd_after_rst");

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
